// File: rtl/vx_gbar_pkg.sv
// vx_gbar_pkg: shared types and constants for the global barrier unit
package vx_gbar_pkg;
    localparam int GBAR_NB_W = 4;
    localparam int GBAR_NC_W = 4;
    localparam logic [1:0] GBAR_ERR_DUP = 2'b01;
    localparam logic [1:0] GBAR_ERR_SIZE = 2'b10;
    typedef struct packed {
        logic [GBAR_NB_W-1:0] id;
        logic [GBAR_NC_W-1:0] size_m1;
        logic [GBAR_NC_W-1:0] core_id;
    } gbar_req_t;
    typedef struct packed {
        logic valid;
        logic is_err;
        logic [1:0] code;
        logic [GBAR_NB_W-1:0] id;
    } gbar_evt_t;
    function automatic int gbar_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vx_gbar_if.sv
// vx_gbar_if: arrival request bus plus release/error broadcast of the barrier unit
interface vx_gbar_if #(
    parameter int NUM_REQS = 4,
    parameter int NB_W = 4,
    parameter int NC_W = 4
);
    logic [NUM_REQS-1:0] req_valid;
    logic [NUM_REQS-1:0] req_ready;
    logic [NUM_REQS*NB_W-1:0] req_id;
    logic [NUM_REQS*NC_W-1:0] req_size_m1;
    logic [NUM_REQS*NC_W-1:0] req_core_id;
    logic rsp_valid;
    logic [NB_W-1:0] rsp_id;
    logic err_valid;
    logic [1:0] err_code;
    logic [NB_W-1:0] err_id;
    modport master (
        output req_valid, req_id, req_size_m1, req_core_id,
        input req_ready, rsp_valid, rsp_id, err_valid, err_code, err_id
    );
    modport slave (
        input req_valid, req_id, req_size_m1, req_core_id,
        output req_ready, rsp_valid, rsp_id, err_valid, err_code, err_id
    );
endinterface

// File: rtl/vx_gbar_table.sv
// vx_gbar_table: per-barrier arrival state with release and protocol-error decisions
module vx_gbar_table
    import vx_gbar_pkg::*;
#(
    parameter int NUM_BARRIERS = 16,
    parameter int NUM_CORES = 16
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      acc,
    input  gbar_req_t req,
    output gbar_evt_t evt
);
    localparam int NB_W = gbar_w(NUM_BARRIERS);
    localparam int NC_W = gbar_w(NUM_CORES);
    localparam int CNT_W = $clog2(NUM_CORES + 1);
    logic [NUM_CORES-1:0] arrived [NUM_BARRIERS];
    logic [CNT_W-1:0] count [NUM_BARRIERS];
    logic [NC_W-1:0] size_m1 [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] size_valid;
    logic [NB_W-1:0] b;
    logic [NC_W-1:0] c, s;
    logic dup, mis, rel;
    assign b = req.id[NB_W-1:0];
    assign c = req.core_id[NC_W-1:0];
    assign s = req.size_m1[NC_W-1:0];
    assign dup = arrived[b][c];
    assign mis = size_valid[b] && size_m1[b] != s;
    // an arrival that finds size_m1 peers already present is the last one
    assign rel = count[b] == CNT_W'(s);
    assign evt = '{
        valid: acc && (dup || mis || rel),
        is_err: dup || mis,
        code: dup ? GBAR_ERR_DUP : mis ? GBAR_ERR_SIZE : 2'b00,
        id: req.id
    };
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                arrived[i] <= '0;
                count[i] <= '0;
            end
            size_valid <= '0;
        end else if (acc && !dup && !mis) begin
            if (rel) begin
                arrived[b] <= '0;
                count[b] <= '0;
                size_valid[b] <= 1'b0;
            end else begin
                arrived[b][c] <= 1'b1;
                count[b] <= count[b] + 1'b1;
                size_m1[b] <= s;
                size_valid[b] <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/vx_gbar_unit.sv
// vx_gbar_unit: arbitrates barrier arrivals and broadcasts releases/errors through a fixed-latency pipe
module vx_gbar_unit
    import vx_gbar_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int NUM_BARRIERS = 16,
    parameter int NUM_CORES = 16,
    parameter int RSP_STAGES = 1,
    parameter string ARBITER = "R"
) (
    input logic clk,
    input logic reset,
    vx_gbar_if.slave bus
);
    localparam int NB_W = gbar_w(NUM_BARRIERS);
    localparam int NC_W = gbar_w(NUM_CORES);
    localparam int RW = gbar_w(NUM_REQS);
    logic [RW-1:0] rr_ptr, start, gnt_idx, pi;
    logic gnt_any;
    int p;
    gbar_req_t req;
    gbar_evt_t evt;
    gbar_evt_t pipe [RSP_STAGES];
    gbar_evt_t last;
    assign start = ARBITER == "P" ? '0 : rr_ptr;
    // scan downwards so the port closest to start wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        req = '0;
        p = 0;
        pi = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            p = (int'(start) + k) % NUM_REQS;
            pi = RW'(p);
            if (bus.req_valid[pi]) begin
                gnt_any = 1'b1;
                gnt_idx = pi;
                req.id = GBAR_NB_W'(bus.req_id[p*NB_W +: NB_W]);
                req.size_m1 = GBAR_NC_W'(bus.req_size_m1[p*NC_W +: NC_W]);
                req.core_id = GBAR_NC_W'(bus.req_core_id[p*NC_W +: NC_W]);
            end
        end
    end
    assign bus.req_ready = (gnt_any && !reset) ? NUM_REQS'(1) << gnt_idx : '0;
    always_ff @(posedge clk) begin
        if (reset) rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= (gnt_idx == RW'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
    end
    vx_gbar_table #(
        .NUM_BARRIERS(NUM_BARRIERS),
        .NUM_CORES(NUM_CORES)
    ) table_i (
        .clk(clk),
        .reset(reset),
        .acc(|bus.req_ready),
        .req(req),
        .evt(evt)
    );
    always_ff @(posedge clk) begin
        pipe[0] <= evt;
        for (int i = 1; i < RSP_STAGES; i++) pipe[i] <= pipe[i-1];
        if (reset) for (int i = 0; i < RSP_STAGES; i++) pipe[i].valid <= 1'b0;
    end
    assign last = pipe[RSP_STAGES-1];
    assign bus.rsp_valid = last.valid && !last.is_err && !reset;
    assign bus.rsp_id = last.id[NB_W-1:0];
    assign bus.err_valid = last.valid && last.is_err && !reset;
    assign bus.err_code = last.code;
    assign bus.err_id = last.id[NB_W-1:0];
endmodule

// File: tb/tb_vx_gbar_unit.sv
// tb_vx_gbar_unit: directed and randomized checks of vx_gbar_unit against a behavioural barrier model
module tb_vx_gbar_unit;
    localparam int N = 4, NB = 16, NC = 16, W = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] v = '0;
    logic [N*W-1:0] id_f = '0, sz_f = '0, cr_f = '0;
    logic [N-1:0] hs = '0;
    int cyc = 0, checks = 0, errors = 0;
    bit [NC-1:0] m_arr [NB];
    int m_sz [NB];
    int m_ptr = 0;
    int mg, me;
    int exp_a [int];
    int exp_b [int];
    int acc_port[$], acc_cyc[$], rsp_a_id[$], rsp_a_cyc[$], rsp_b_id[$], rsp_b_cyc[$], err_code_q[$], err_id_q[$];
    always #5 clk = ~clk;
    vx_gbar_if #(.NUM_REQS(N), .NB_W(W), .NC_W(W)) ifa ();
    vx_gbar_if #(.NUM_REQS(N), .NB_W(W), .NC_W(W)) ifb ();
    assign ifa.req_valid = v;
    assign ifa.req_id = id_f;
    assign ifa.req_size_m1 = sz_f;
    assign ifa.req_core_id = cr_f;
    assign ifb.req_valid = v;
    assign ifb.req_id = id_f;
    assign ifb.req_size_m1 = sz_f;
    assign ifb.req_core_id = cr_f;
    vx_gbar_unit #(.NUM_REQS(N), .NUM_BARRIERS(NB), .NUM_CORES(NC), .RSP_STAGES(1), .ARBITER("R")) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    vx_gbar_unit #(.NUM_REQS(N), .NUM_BARRIERS(NB), .NUM_CORES(NC), .RSP_STAGES(3), .ARBITER("R")) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic chk_out(input string t, input logic rv, input logic [W-1:0] rid, input logic ev,
                           input logic [1:0] ec, input logic [W-1:0] eid, input bit has, input int enc);
        bit is_err;
        is_err = enc[16];
        chk({t, "rsp_valid"}, 32'(rv), 32'(has && !is_err));
        chk({t, "err_valid"}, 32'(ev), 32'(has && is_err));
        if (has && !is_err) chk({t, "rsp_id"}, 32'(rid), enc & 255);
        if (has && is_err) begin
            chk({t, "err_code"}, 32'(ec), (enc >> 8) & 3);
            chk({t, "err_id"}, 32'(eid), enc & 255);
        end
    endtask
    // barrier rules: encoded result is (is_err<<16)|(code<<8)|id, or -1 when nothing is broadcast
    function automatic int m_accept(int b, int c, int s);
        int present;
        present = $countones(m_arr[b]);
        if (m_arr[b][c]) return (1 << 16) | (1 << 8) | b;
        if (present != 0 && m_sz[b] != s) return (1 << 16) | (2 << 8) | b;
        if (present == s) begin
            m_arr[b] = '0;
            return b;
        end
        m_arr[b][c] = 1'b1;
        m_sz[b] = s;
        return -1;
    endfunction
    always @(negedge clk) begin
        cyc++;
        chk_out("a.", ifa.rsp_valid, ifa.rsp_id, ifa.err_valid, ifa.err_code, ifa.err_id,
                !reset && exp_a.exists(cyc), exp_a.exists(cyc) ? exp_a[cyc] : 0);
        chk_out("b.", ifb.rsp_valid, ifb.rsp_id, ifb.err_valid, ifb.err_code, ifb.err_id,
                !reset && exp_b.exists(cyc), exp_b.exists(cyc) ? exp_b[cyc] : 0);
        if (ifa.rsp_valid) begin rsp_a_id.push_back(int'(ifa.rsp_id)); rsp_a_cyc.push_back(cyc); end
        if (ifb.rsp_valid) begin rsp_b_id.push_back(int'(ifb.rsp_id)); rsp_b_cyc.push_back(cyc); end
        if (ifa.err_valid) begin err_code_q.push_back(int'(ifa.err_code)); err_id_q.push_back(int'(ifa.err_id)); end
        exp_a.delete(cyc);
        exp_b.delete(cyc);
        if (reset) begin
            chk("a.ready_in_reset", 32'(ifa.req_ready), 0);
            chk("b.ready_in_reset", 32'(ifb.req_ready), 0);
            foreach (m_arr[i]) m_arr[i] = '0;
            m_ptr = 0;
            exp_a.delete();
            exp_b.delete();
            hs = '0;
        end else begin
            mg = -1;
            for (int k = 0; k < N; k++) if (mg < 0 && v[(m_ptr + k) % N]) mg = (m_ptr + k) % N;
            chk("a.req_ready", 32'(ifa.req_ready), mg < 0 ? 0 : 1 << mg);
            chk("b.req_ready", 32'(ifb.req_ready), mg < 0 ? 0 : 1 << mg);
            hs = ifa.req_valid & ifa.req_ready;
            if (mg >= 0) begin
                m_ptr = (mg + 1) % N;
                acc_port.push_back(mg);
                acc_cyc.push_back(cyc);
                me = m_accept(int'(id_f[mg*W +: W]), int'(cr_f[mg*W +: W]), int'(sz_f[mg*W +: W]));
                if (me >= 0) begin
                    exp_a[cyc + 1] = me;
                    exp_b[cyc + 3] = me;
                end
            end
        end
    end
    task automatic clear_logs();
        acc_port.delete(); acc_cyc.delete(); rsp_a_id.delete(); rsp_a_cyc.delete();
        rsp_b_id.delete(); rsp_b_cyc.delete(); err_code_q.delete(); err_id_q.delete();
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        v = v & ~hs;
    endtask
    task automatic set_req(input int p, input int b, input int s, input int c);
        v[p] = 1'b1;
        id_f[p*W +: W] = W'(b);
        sz_f[p*W +: W] = W'(s);
        cr_f[p*W +: W] = W'(c);
    endtask
    task automatic drain();
        int n;
        n = 0;
        while (v != '0 && n < 64) begin tick(); n++; end
        chk("drain_within_budget", 32'(v), 0);
    endtask
    task automatic send(input int p, input int b, input int s, input int c);
        set_req(p, b, s, c);
        drain();
    endtask
    task automatic settle();
        repeat (5) tick();
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_logs();
    endtask
    initial begin
        repeat (2) tick();
        reset = 1'b0;
        // four participants on four ports, rotating grants
        do_reset();
        for (int p = 0; p < N; p++) set_req(p, 6, 3, p);
        drain();
        settle();
        chk("s1.accepts", acc_port.size(), 4);
        for (int i = 0; i < acc_port.size(); i++) chk("s1.grant_order", acc_port[i], i);
        chk("s1.model_ptr_wrapped", m_ptr, 0);
        chk("s1.rsp_count", rsp_a_id.size(), 1);
        if (rsp_a_id.size() == 1 && acc_cyc.size() == 4) begin
            chk("s1.rsp_id", rsp_a_id[0], 6);
            chk("s1.accept_span", acc_cyc[3] - acc_cyc[0], 3);
            chk("s1.rsp_latency", rsp_a_cyc[0] - acc_cyc[3], 1);
        end
        // duplicate arrival, then completion by another core
        do_reset();
        send(0, 5, 1, 2);
        send(0, 5, 1, 2);
        send(0, 5, 1, 7);
        settle();
        chk("s2.err_count", err_code_q.size(), 1);
        if (err_code_q.size() == 1) begin
            chk("s2.err_code", err_code_q[0], 1);
            chk("s2.err_id", err_id_q[0], 5);
        end
        chk("s2.rsp_count", rsp_a_id.size(), 1);
        if (rsp_a_id.size() == 1) chk("s2.rsp_id", rsp_a_id[0], 5);
        // size mismatch leaves the barrier untouched
        do_reset();
        send(0, 3, 2, 0);
        send(0, 3, 3, 1);
        settle();
        chk("s3.model_count_after_mismatch", $countones(m_arr[3]), 1);
        chk("s3.err_count", err_code_q.size(), 1);
        if (err_code_q.size() == 1) begin
            chk("s3.err_code", err_code_q[0], 2);
            chk("s3.err_id", err_id_q[0], 3);
        end
        send(0, 3, 2, 1);
        settle();
        chk("s3.no_early_release", rsp_a_id.size(), 0);
        send(0, 3, 2, 2);
        settle();
        chk("s3.rsp_count", rsp_a_id.size(), 1);
        if (rsp_a_id.size() == 1) chk("s3.rsp_id", rsp_a_id[0], 3);
        // single participant releases immediately, deep pipe shows it three cycles later
        do_reset();
        send(1, 9, 0, 4);
        settle();
        chk("s4.b_rsp_count", rsp_b_id.size(), 1);
        if (rsp_b_id.size() == 1 && acc_cyc.size() == 1) begin
            chk("s4.b_rsp_id", rsp_b_id[0], 9);
            chk("s4.b_latency", rsp_b_cyc[0] - acc_cyc[0], 3);
        end
        if (rsp_a_cyc.size() == 1 && acc_cyc.size() == 1) chk("s4.a_latency", rsp_a_cyc[0] - acc_cyc[0], 1);
        // reset discards a partially filled barrier
        do_reset();
        send(0, 1, 3, 0);
        send(0, 1, 3, 1);
        do_reset();
        send(0, 1, 3, 2);
        send(0, 1, 3, 3);
        send(0, 1, 3, 0);
        settle();
        chk("s5.no_release_after_reset", rsp_a_id.size(), 0);
        send(0, 1, 3, 1);
        settle();
        chk("s5.rsp_count", rsp_a_id.size(), 1);
        if (rsp_a_id.size() == 1) chk("s5.rsp_id", rsp_a_id[0], 1);
        // two releases on consecutive accepts
        do_reset();
        set_req(0, 2, 1, 0);
        set_req(1, 4, 1, 0);
        drain();
        set_req(0, 2, 1, 1);
        set_req(1, 4, 1, 1);
        drain();
        settle();
        chk("s6.rsp_count", rsp_a_id.size(), 2);
        if (rsp_a_id.size() == 2) begin
            chk("s6.first_id", rsp_a_id[0], 2);
            chk("s6.second_id", rsp_a_id[1], 4);
            chk("s6.consecutive", rsp_a_cyc[1] - rsp_a_cyc[0], 1);
        end
        // random traffic on a few barriers, with occasional resets
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int p = 0; p < N; p++)
                if (!v[p] && $urandom_range(0, 2) == 0)
                    set_req(p, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, NC - 1));
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        drain();
        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_gbar_unit.md
Name: vx_gbar_unit

Overview:
- Central global-barrier unit. It arbitrates barrier-arrival requests from NUM_REQS clusters/cores and tracks per-barrier arrival state.
- When the last expected participant arrives, it broadcasts a release (barrier id) to all requesters through a configurable response pipeline.
- It also flags protocol errors: duplicate arrival and size mismatch.

Parameters:
- NUM_REQS, 4, number of requester ports.
- NUM_BARRIERS, 16, number of barrier ids tracked; NB_W = max(1, clog2(NUM_BARRIERS)).
- NUM_CORES, 16, number of distinct participant ids; NC_W = max(1, clog2(NUM_CORES)).
- RSP_STAGES, 1, release/error pipeline depth (>=1).
- ARBITER, "R", request arbitration policy: "R" round-robin, "P" fixed priority (port 0 highest).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQS  arrival request valid per port
- req_id  in  NUM_REQS*NB_W  barrier id per port
- req_size_m1  in  NUM_REQS*NC_W  participant count minus one
- req_core_id  in  NUM_REQS*NC_W  arriving participant id
- req_ready  out  NUM_REQS  request accepted this cycle (one-hot or zero)
- rsp_valid  out  1  release broadcast pulse
- rsp_id  out  NB_W  released barrier id
- err_valid  out  1  protocol-error pulse
- err_code  out  2  01 duplicate arrival, 10 size mismatch
- err_id  out  NB_W  barrier id of the error

Behaviour:
- Clock is clk; reset is synchronous, active-high, named reset.
- Reset clears all arrival masks, counts, size-valid flags and pipeline valids, and sets the RR pointer to port 0.
  - During reset: rsp_valid=0, err_valid=0, req_ready=0.
  - A barrier in progress is discarded; no release is issued for it.
- Arbitration: at most one request is accepted per cycle. req_ready[i]=1 only for the granted valid port. Handshake is valid&ready.
  - Round-robin: after a grant to port i, priority starts at i+1 (wrap to 0).
  - The pointer does not advance on idle cycles.
  - Requesters hold valid/data stable until ready.
- Per-barrier state: arrived[NUM_CORES] mask, count (clog2(NUM_CORES+1) bits), size_m1 register, size_valid flag.
- Accepted request (id B, core C, size S):
  - arrived[C] already set -> duplicate error (code 01). State unchanged.
  - size_valid and S != stored size -> mismatch error (code 10). State unchanged. Duplicate takes precedence if both apply.
  - Otherwise set arrived[C], count+1, latch S and set size_valid on the first arrival.
  - If the pre-increment count == S: release B. Clear the mask, zero the count, clear size_valid in the same cycle.
  - S=0 releases on the single arrival.
- Back-to-back accepts to the same barrier are read-after-write correct (single-cycle update, no forwarding hazard). Accept in cycle t sees the update from t-1.
- A request to B in the cycle after B's release starts a new episode.
- Release/error latency: an event from the accept in cycle t appears on rsp_*/err_* in cycle t+RSP_STAGES as a single-cycle pulse.
  - Pipeline has no backpressure. Consecutive releases appear on consecutive cycles.
  - rsp_valid and err_valid are never both set for the same accept.
- rsp_id/err_id/err_code hold don't-care values when the corresponding valid is 0. Data registers are not reset.

Decomposition:
- Package vx_gbar_pkg holds:
  - err_code constants (GBAR_ERR_DUP=2'b01, GBAR_ERR_SIZE=2'b10);
  - typedef gbar_req_t {id, size_m1, core_id};
  - typedef gbar_evt_t {valid, is_err, code, id}.
- One natural sub-module: vx_gbar_table, the per-barrier state array plus update/release/error decision logic.
- Arbitration reuses the existing stream arbiter, unbuffered, with an output ready of constant 1.
- The response pipeline is a shift register of gbar_evt_t.

Test Plan:
- Size 4 (S=3), cores 0,1,2,3 arrive on ports 0..3 simultaneously, RSP_STAGES=1 -> accepts in 4 consecutive cycles with rotating grant 0,1,2,3. rsp_valid=1, rsp_id=id one cycle after the 4th accept, exactly once.
- Barrier 5, S=1: core 2 arrives, then core 2 again -> err_valid with code 01, err_id=5. Then core 7 arrives -> release id 5.
- Barrier 3: first arrival S=2, second arrival S=3 -> err code 10, count stays 1. The barrier later completes with S=2 arrivals.
- S=0 single arrival on barrier 9 with RSP_STAGES=3 -> rsp_valid at accept+3, rsp_id=9.
- Barrier 1 has 2 of 4 arrivals when reset is asserted for 1 cycle. Then 2 new arrivals -> no release; release only after 4 fresh arrivals.
- Two barriers complete on consecutive accepts (ids 2 then 4) -> rsp pulses on consecutive cycles with ids 2, 4. No release is dropped or merged.
